// File: rtl/inst_fetcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetcher_pkg
//  Description : Shared types and defaults for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetcher_pkg;

    // Default cache geometry: log2 of line count, one 32-bit word per line.
    localparam int unsigned c_ICACHE_SIZE_BIT_DEFAULT = 6;
    localparam int unsigned c_XLEN                    = 32;

    typedef logic [c_XLEN-1:0] word_t;

    // Instruction slot presented to the decoder.
    typedef struct packed {
        logic  valid;
        word_t addr;
        word_t data;
    } fetch_slot_t;

    // Outstanding memory-controller read.
    typedef struct packed {
        logic  req;
        word_t addr;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetcher_if
//  Description : Decoder, ROB-redirect and memory-controller signals of the
//                fetch stage. master = fetcher side, slave = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    // decoder handshake
    logic  inst_valid;
    word_t inst_addr;
    word_t inst_data;
    logic  f_ok;
    word_t f_next_pc;
    // ROB redirect
    logic  rob_clear;
    word_t rob_new_pc;
    // memory controller
    logic  mc_req;
    word_t mc_addr;
    logic  mc_done;
    word_t mc_data;

    modport master (
        output inst_valid, inst_addr, inst_data, mc_req, mc_addr,
        input  f_ok, f_next_pc, rob_clear, rob_new_pc, mc_done, mc_data
    );

    modport slave (
        input  inst_valid, inst_addr, inst_data, mc_req, mc_addr,
        output f_ok, f_next_pc, rob_clear, rob_new_pc, mc_done, mc_data
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetcher_icache_array.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetcher_icache_array
//  Description : Direct-mapped instruction cache storage. Combinational
//                hit/data for a lookup address, synchronous fill port.
//                Only the valid bits are reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetcher_icache_array
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_SIZE_BIT = c_ICACHE_SIZE_BIT_DEFAULT
) (
    input  wire logic  clk_in,
    input  wire logic  rst_in,
    input  wire word_t i_lookup_addr,
    output logic       o_lookup_hit,
    output word_t      o_lookup_data,
    input  wire logic  i_wr_en,
    input  wire word_t i_wr_addr,
    input  wire word_t i_wr_data
);

    localparam int unsigned c_LINES = 1 << ICACHE_SIZE_BIT;
    localparam int unsigned c_TAG_W = c_XLEN - ICACHE_SIZE_BIT - 2;

    logic [c_LINES-1:0]         r_valid;
    logic [c_TAG_W-1:0]         r_tag  [c_LINES];
    word_t                      r_data [c_LINES];

    logic [ICACHE_SIZE_BIT-1:0] w_rd_idx;
    logic [ICACHE_SIZE_BIT-1:0] w_wr_idx;
    logic [c_TAG_W-1:0]         w_rd_tag;
    logic [c_TAG_W-1:0]         w_wr_tag;
    logic                       w_unused_byte_offset;

    // Byte offset bits play no part: every PC is treated as word-aligned.
    assign w_rd_idx = i_lookup_addr[ICACHE_SIZE_BIT+1:2];
    assign w_rd_tag = i_lookup_addr[c_XLEN-1:ICACHE_SIZE_BIT+2];
    assign w_wr_idx = i_wr_addr[ICACHE_SIZE_BIT+1:2];
    assign w_wr_tag = i_wr_addr[c_XLEN-1:ICACHE_SIZE_BIT+2];
    assign w_unused_byte_offset = &{1'b0, i_lookup_addr[1:0], i_wr_addr[1:0]};

    assign o_lookup_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_lookup_data = r_data[w_rd_idx];

    // Valid bits: cleared by reset, set by a fill; never invalidated otherwise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: overwritten on every fill, no reset.
    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetcher
//  Description : Instruction fetch stage. Holds the PC, looks up a
//                direct-mapped I-cache, fetches misses through the memory
//                controller and presents one instruction per cycle to the
//                decoder on a valid/consume handshake. ROB clear redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_SIZE_BIT = c_ICACHE_SIZE_BIT_DEFAULT,
    parameter word_t       RESET_PC        = 32'h0
) (
    input  wire logic       clk_in,
    input  wire logic       rst_in,
    input  wire logic       rdy_in,
    inst_fetcher_if.master  bus
);

    localparam logic [0:0] c_RUN  = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    word_t       r_pc;
    word_t       w_pc_next;
    fetch_slot_t r_slot;
    fetch_slot_t w_slot_next;
    mem_req_t    r_mreq;
    mem_req_t    w_mreq_next;

    word_t       w_lookup_addr;
    logic        w_hit;
    word_t       w_hit_data;
    logic        w_hold;
    logic        w_fill_en;

    // The decoder may consume and redirect in one cycle, so lookup follows
    // f_next_pc whenever the current slot is being taken.
    assign w_lookup_addr = (r_slot.valid && bus.f_ok) ? bus.f_next_pc : r_pc;
    assign w_hold        = r_slot.valid && !bus.f_ok;
    assign w_fill_en     = rdy_in && (r_state == c_WAIT) && bus.mc_done;

    inst_fetcher_icache_array #(
        .ICACHE_SIZE_BIT (ICACHE_SIZE_BIT)
    ) u_icache (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .i_lookup_addr (w_lookup_addr),
        .o_lookup_hit  (w_hit),
        .o_lookup_data (w_hit_data),
        .i_wr_en       (w_fill_en),
        .i_wr_addr     (r_mreq.addr),
        .i_wr_data     (bus.mc_data)
    );

    // FSM state register; frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= c_RUN;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    // Next state: a RUN lookup that misses goes to WAIT; mc_done returns.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_RUN: begin
                if (!bus.rob_clear && !w_hold && !w_hit) begin
                    w_state_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (bus.mc_done) begin
                    w_state_next = c_RUN;
                end
            end
            default: w_state_next = c_RUN;
        endcase
    end

    // Output/datapath next values; priority rob_clear > mc_done > f_ok > hold.
    always_comb begin
        w_pc_next   = r_pc;
        w_slot_next = r_slot;
        w_mreq_next = r_mreq;
        case (r_state)
            c_RUN: begin
                if (bus.rob_clear) begin
                    w_pc_next         = bus.rob_new_pc;
                    w_slot_next.valid = 1'b0;
                end else if (!w_hold) begin
                    w_pc_next = w_lookup_addr;
                    if (w_hit) begin
                        w_slot_next = '{valid: 1'b1, addr: w_lookup_addr, data: w_hit_data};
                    end else begin
                        w_slot_next.valid = 1'b0;
                        w_mreq_next       = '{req: 1'b1, addr: w_lookup_addr};
                    end
                end
            end
            c_WAIT: begin
                if (bus.mc_done) begin
                    w_mreq_next.req = 1'b0;
                    if (bus.rob_clear) begin
                        w_pc_next         = bus.rob_new_pc;
                        w_slot_next.valid = 1'b0;
                    end else if (r_pc == r_mreq.addr) begin
                        // Forward the fill word straight to the decoder.
                        w_slot_next = '{valid: 1'b1, addr: r_pc, data: bus.mc_data};
                    end else begin
                        // PC moved during the miss; next RUN cycle looks it up.
                        w_slot_next.valid = 1'b0;
                    end
                end else if (bus.rob_clear) begin
                    // Request stays outstanding; only the PC is redirected.
                    w_pc_next = bus.rob_new_pc;
                end
            end
            default: begin
                w_slot_next.valid = 1'b0;
            end
        endcase
    end

    // Datapath registers: PC, presented slot and memory request.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pc   <= RESET_PC;
            r_slot <= '0;
            r_mreq <= '0;
        end else if (rdy_in) begin
            r_pc   <= w_pc_next;
            r_slot <= w_slot_next;
            r_mreq <= w_mreq_next;
        end
    end

    assign bus.inst_valid = r_slot.valid;
    assign bus.inst_addr  = r_slot.addr;
    assign bus.inst_data  = r_slot.data;
    assign bus.mc_req     = r_mreq.req;
    assign bus.mc_addr    = r_mreq.addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetcher
//  Description : Self-checking bench for inst_fetcher: directed scenarios
//                followed by randomized decoder/ROB/memory traffic compared
//                against a behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    localparam int IB = 6;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;

    inst_fetcher_if bus();

    inst_fetcher #(
        .ICACHE_SIZE_BIT (IB),
        .RESET_PC        (32'h0)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // behavioural model state
    bit          m_iv, m_req, m_wait;
    logic [31:0] m_ia, m_id, m_pc, m_ma;
    int          lat_cnt, lat_next;
    bit          rand_lat;
    logic [31:0] c_addr [int];
    logic [31:0] c_data [int];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    function automatic int cidx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << IB));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int i = cidx(a);
        if (!c_addr.exists(i)) return 1'b0;
        return (c_addr[i] >> (IB + 2)) == (a >> (IB + 2));
    endfunction

    task automatic model_reset();
        m_iv = 0; m_ia = 0; m_id = 0; m_pc = 0;
        m_req = 0; m_ma = 0; m_wait = 0; lat_cnt = 0;
        c_addr.delete();
        c_data.delete();
    endtask

    // One clock edge of the fetch stage, written from its rules.
    task automatic model_step();
        logic [31:0] la;
        if (!rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        if (!m_wait) begin
            la = (m_iv && bus.f_ok) ? bus.f_next_pc : m_pc;
            if (bus.rob_clear) begin
                m_pc = bus.rob_new_pc; m_iv = 0;
            end else if (m_iv && !bus.f_ok) begin
                m_iv = 1;
            end else if (m_hit(la)) begin
                m_iv = 1; m_ia = la; m_id = c_data[cidx(la)]; m_pc = la;
            end else begin
                m_iv = 0; m_pc = la; m_req = 1; m_ma = la; m_wait = 1;
                lat_cnt = rand_lat ? int'($urandom_range(0, 3)) : lat_next;
            end
        end else if (bus.mc_done) begin
            c_addr[cidx(m_ma)] = m_ma;
            c_data[cidx(m_ma)] = bus.mc_data;
            m_req = 0; m_wait = 0;
            if (bus.rob_clear) begin
                m_pc = bus.rob_new_pc; m_iv = 0;
            end else if (m_pc == m_ma) begin
                m_iv = 1; m_ia = m_pc; m_id = bus.mc_data;
            end else begin
                m_iv = 0;
            end
        end else begin
            if (bus.rob_clear) m_pc = bus.rob_new_pc;
            if (lat_cnt > 0) lat_cnt--;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk_in) begin
        #1;
        if (chk_en) begin
            chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_iv});
            if (m_iv) begin
                chk("inst_addr", bus.inst_addr, m_ia);
                chk("inst_data", bus.inst_data, m_id);
            end
            chk("mc_req", {31'd0, bus.mc_req}, {31'd0, m_req});
            if (m_req) chk("mc_addr", bus.mc_addr, m_ma);
        end
    end

    // Drive one cycle of inputs; memory controller answers from the model's request.
    task automatic cyc(input bit rdy, input bit fok, input logic [31:0] npc,
                       input bit clr, input logic [31:0] tgt);
        @(negedge clk_in);
        rdy_in         = rdy;
        bus.f_ok       = fok;
        bus.f_next_pc  = npc;
        bus.rob_clear  = clr;
        bus.rob_new_pc = tgt;
        bus.mc_done    = m_req && (lat_cnt == 0);
        bus.mc_data    = m_req ? mem_word(m_ma) : 32'hDEAD_BEEF;
        @(posedge clk_in);
        model_step();
    endtask

    task automatic idle_until_valid(input int budget);
        int n = 0;
        while (!m_iv && n < budget) begin
            cyc(1, 0, 32'h0, 0, 32'h0);
            n++;
        end
        n_tests++;
        if (!m_iv) begin
            n_fail++;
            $display("FAIL wait_valid: got timeout expected valid within %0d cycles", budget);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    initial begin
        bus.f_ok = 0; bus.f_next_pc = 0; bus.rob_clear = 0; bus.rob_new_pc = 0;
        bus.mc_done = 0; bus.mc_data = 0;
        rand_lat = 0; lat_next = 2;
        model_reset();
        chk_en = 1;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #2 rst_in = 1'b1;

        // first cycle out of reset misses on RESET_PC
        cyc(1, 0, 0, 0, 0);
        #2;
        lit("rst_mc_req", {31'd0, bus.mc_req}, 32'd1);
        lit("rst_mc_addr", bus.mc_addr, 32'h0);
        idle_until_valid(20);
        #2;
        lit("first_valid", {31'd0, bus.inst_valid}, 32'd1);
        lit("first_addr", bus.inst_addr, 32'h0);
        lit("first_data", bus.inst_data, 32'h0000_0013);

        // preload 0x4..0xC, redirect to 0, stream hits
        for (int a = 4; a <= 12; a += 4) begin
            cyc(1, 1, a, 0, 0);
            idle_until_valid(20);
        end
        cyc(1, 0, 0, 1, 32'h0);
        cyc(1, 0, 0, 0, 0);
        #2;
        lit("stream_addr0", bus.inst_addr, 32'h0);
        for (int a = 4; a <= 12; a += 4) begin
            cyc(1, 1, a, 0, 0);
            #2;
            lit("stream_valid", {31'd0, bus.inst_valid}, 32'd1);
            lit("stream_addr", bus.inst_addr, a);
            lit("stream_no_req", {31'd0, bus.mc_req}, 32'd0);
        end

        // decoder stall, then consume into a miss
        cyc(1, 1, 32'h10, 0, 0);
        idle_until_valid(20);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 32'h44, 0, 0);
            #2;
            lit("stall_addr", bus.inst_addr, 32'h10);
            lit("stall_data", bus.inst_data, 32'h0000_0003);
        end
        cyc(1, 1, 32'h40, 0, 0);
        #2;
        lit("stall_miss_valid", {31'd0, bus.inst_valid}, 32'd0);
        lit("stall_miss_req", {31'd0, bus.mc_req}, 32'd1);
        lit("stall_miss_addr", bus.mc_addr, 32'h40);
        idle_until_valid(20);

        // rob_clear during a miss; redirect target already cached
        cyc(1, 1, 32'h2C0, 0, 0);
        idle_until_valid(20);
        lat_next = 4;
        cyc(1, 1, 32'h100, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h2C0);
        for (int i = 0; i < 10 && m_req; i++) cyc(1, 0, 0, 0, 0);
        #2;
        lit("clr_fill_valid", {31'd0, bus.inst_valid}, 32'd0);
        lit("clr_fill_req", {31'd0, bus.mc_req}, 32'd0);
        cyc(1, 0, 0, 0, 0);
        #2;
        lit("clr_target_addr", bus.inst_addr, 32'h2C0);
        cyc(1, 1, 32'h100, 0, 0);
        #2;
        lit("clr_line_hit", bus.inst_data, 32'h0000_0113);

        // index conflict between 0x0 and 0x100
        lat_next = 1;
        cyc(1, 1, 32'h0, 0, 0);
        idle_until_valid(20);
        cyc(1, 1, 32'h100, 0, 0);
        #2;
        lit("conf_addr_100", bus.mc_addr, 32'h100);
        idle_until_valid(20);
        cyc(1, 1, 32'h0, 0, 0);
        #2;
        lit("conf_req", {31'd0, bus.mc_req}, 32'd1);
        lit("conf_addr_0", bus.mc_addr, 32'h0);
        idle_until_valid(20);

        // rdy_in low with mc_done pending
        lat_next = 0;
        cyc(1, 1, 32'h300, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            #2;
            lit("rdy_hold_req", {31'd0, bus.mc_req}, 32'd1);
            lit("rdy_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
        end
        cyc(1, 0, 0, 0, 0);
        #2;
        lit("rdy_fill_addr", bus.inst_addr, 32'h300);
        lit("rdy_fill_data", bus.inst_data, 32'h0000_0313);

        // asynchronous reset in the middle of a miss
        lat_next = 5;
        cyc(1, 1, 32'h500, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #3 rst_in = 1'b0;
        #1;
        lit("async_rst_req", {31'd0, bus.mc_req}, 32'd0);
        lit("async_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        model_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #2 rst_in = 1'b1;
        cyc(1, 0, 0, 0, 0);
        #2;
        lit("post_rst_miss", {31'd0, bus.mc_req}, 32'd1);
        idle_until_valid(20);

        // randomized traffic
        rand_lat = 1;
        for (int i = 0; i < 2000; i++) begin
            bit          rdy, fok, clr;
            logic [31:0] npc, tgt;
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 13) == 0);
            fok = m_iv ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            npc = ($urandom_range(0, 9) < 7) ? m_ia + 32'd4 : 32'($urandom_range(0, 255)) * 32'd4;
            tgt = 32'($urandom_range(0, 255)) * 32'd4;
            cyc(rdy, fok, npc, clr, tgt);
        end

        @(negedge clk_in);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
